// File: rtl/add8b_seq_pkg.sv
// add8b_seq_pkg: shared ALU constants and sequencer state encoding
//   DATASIZE_DEF : default operand width, shared with sub8b
//   state_t      : IDLE=0, RUN=1, DONE=2 (code 3 falls back to IDLE)
package add8b_seq_pkg;
    localparam int DATASIZE_DEF = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/alu_fadd1b.sv
// alu_fadd1b: one-bit full adder cell, shared with sub8b (which feeds it inverted K)
//   a, b, ci : operand bits and carry-in
//   s, co, p : sum, carry-out, propagate a^b
module alu_fadd1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co,
    output logic p
);
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (p & ci);
endmodule

// File: rtl/add8b_seq.sv
// add8b_seq: bit-serial add-with-carry, one bit per clock, LSB first
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start        : request, accepted only in IDLE or DONE
//   j, k, cin    : operands and carry-in, latched on an accepted start
//   s, c, p      : sum, per-bit carry-out (c[MSB] = final carry), per-bit propagate
//   busy, done   : high while adding; one-cycle pulse when s/c/p are final
module add8b_seq
    import add8b_seq_pkg::*;
#(
    parameter int DATASIZE = DATASIZE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATASIZE-1:0] j,
    input  logic [DATASIZE-1:0] k,
    input  logic                cin,
    output logic [DATASIZE-1:0] s,
    output logic [DATASIZE-1:0] c,
    output logic [DATASIZE-1:0] p,
    output logic                busy,
    output logic                done
);
    localparam int CNTSIZE = $clog2(DATASIZE);
    localparam logic [CNTSIZE-1:0] LAST = CNTSIZE'(DATASIZE - 1);

    state_t              state;
    logic [CNTSIZE-1:0]  cnt;
    logic [DATASIZE-1:0] j_r, k_r;
    logic                cin_r;
    logic                fa_ci, fa_s, fa_co, fa_p;

    // Carry into bit n is the carry already written out for bit n-1.
    assign fa_ci = (cnt == '0) ? cin_r : c[cnt - 1'b1];

    alu_fadd1b u_fa (
        .a (j_r[cnt]),
        .b (k_r[cnt]),
        .ci(fa_ci),
        .s (fa_s),
        .co(fa_co),
        .p (fa_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            j_r   <= '0;
            k_r   <= '0;
            cin_r <= 1'b0;
            s     <= '0;
            c     <= '0;
            p     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        j_r   <= j;
                        k_r   <= k;
                        cin_r <= cin;
                        s     <= '0;
                        c     <= '0;
                        p     <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s[cnt] <= fa_s;
                    c[cnt] <= fa_co;
                    p[cnt] <= fa_p;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_add8b_seq.sv
// tb_add8b_seq: random and directed checks of add8b_seq (8-bit) plus exhaustive 4-bit
module tb_add8b_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, cin8, busy8, done8;
    logic [7:0] j8, k8, s8, c8, p8;
    logic       start4, cin4, busy4, done4;
    logic [3:0] j4, k4, s4, c4, p4;
    int         errs = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    add8b_seq #(.DATASIZE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .j(j8), .k(k8), .cin(cin8),
        .s(s8), .c(c8), .p(p8), .busy(busy8), .done(done8)
    );

    add8b_seq #(.DATASIZE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .j(j4), .k(k4), .cin(cin4),
        .s(s4), .c(c4), .p(p4), .busy(busy4), .done(done4)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Carry out of bit i is whether the low i+1 bits of the operands overflow.
    function automatic int ref_carry(input int w, input int a, input int b, input int ci);
        int r = 0;
        for (int i = 0; i < w; i++) begin
            int m = 1 << (i + 1);
            if ((a % m) + (b % m) + ci >= m) r |= (1 << i);
        end
        return r;
    endfunction

    // Called on a negedge; returns on the negedge where done is seen (the DONE cycle).
    task automatic op8(input int a, input int b, input int ci);
        int lat = 0;
        int t = a + b + ci;
        j8 = 8'(a); k8 = 8'(b); cin8 = ci[0]; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        j8 = 8'($urandom); k8 = 8'($urandom); cin8 = 1'($urandom);
        check("busy8", int'(busy8), 1);
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("lat8", lat, 8);
        check("s8", int'(s8), t % 256);
        check("c8", int'(c8), ref_carry(8, a, b, ci));
        check("p8", int'(p8), a ^ b);
        check("cy_s8", int'({c8[7], s8}), t % 512);
    endtask

    task automatic op4(input int a, input int b, input int ci);
        int lat = 0;
        int t = a + b + ci;
        j4 = 4'(a); k4 = 4'(b); cin4 = ci[0]; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        while (!done4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("lat4", lat, 4);
        check("s4", int'(s4), t % 16);
        check("c4", int'(c4), ref_carry(4, a, b, ci));
        check("p4", int'(p4), a ^ b);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        start8 = 1'b0; j8 = '0; k8 = '0; cin8 = 1'b0;
        start4 = 1'b0; j4 = '0; k4 = '0; cin4 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out", int'({s8, c8, p8, busy8, done8}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-RUN after three bits of 0x0F+0x01
        j8 = 8'h0F; k8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_c", int'(c8), 32'h07);
        rst_n = 1'b0;
        #1;
        check("midrst_out", int'({s8, c8, p8, busy8, done8}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) seen++;
        end
        check("post_rst_idle", seen, 0);
        check("post_rst_out", int'({s8, c8, p8}), 0);

        // Directed cases
        op8(8'h0F, 8'h01, 0);
        check("ac_flag", int'(c8[3]), 1);
        @(negedge clk);
        check("done_pulse", int'(done8), 0);
        check("hold_s", int'(s8), 32'h10);
        check("hold_c", int'(c8), 32'h0F);
        op8(8'hFF, 8'h00, 1);
        @(negedge clk);
        op8(8'h80, 8'h80, 0);
        check("cy_flag", int'(c8[7]), 1);
        op8(8'h00, 8'h00, 0);
        @(negedge clk);

        // Start pulsed mid-RUN must be ignored
        j8 = 8'h37; k8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        j8 = 8'h11; k8 = 8'h22; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("busy_ign", int'(busy8), 1);
        seen = 0;
        while (!done8 && seen < 40) begin
            @(negedge clk);
            seen++;
        end
        check("ign_lat", seen, 4);
        check("ign_s", int'(s8), 32'h38);
        @(negedge clk);
        check("ign_idle", int'({busy8, done8}), 0);

        // Random 8-bit, mixing back-to-back and idle-gap starts
        repeat (1500) begin
            op8(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)));
            if ($urandom_range(1) == 1) @(negedge clk);
        end
        op8(255, 255, 1);
        @(negedge clk);

        // Exhaustive 4-bit, back-to-back
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int ci = 0; ci < 2; ci++)
                    op4(a, b, ci);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
